keccak_absorb_ctrl: RTL and testbench
=====================================

KECCAK_ABSORB_CTRL -- requirements
Module: keccak_absorb_ctrl

Interface
REQ-001 SHALL have parameter RATE_BITS, default 1088, meaning the SHA3-256 rate and the input block width.
REQ-002 SHALL have parameter STATE_BITS, default 1600, meaning the Keccak state width.
REQ-003 SHALL have parameter DIGEST_BITS, default 256, meaning the digest width.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 local_clk  input  1  clock; all state changes on the rising edge.
REQ-006 in_valid  input  1  in_data is presented.
REQ-007 in_data  input  RATE_BITS  packed block; byte k = in_data[8k+7:8k] (the first packed byte is in byte 0).
REQ-008 in_last  input  1  block is the final block of the message.
REQ-009 in_nbytes  input  8  valid bytes in the final block (0..136); ignored when in_last=0.
REQ-010 in_ready  output  1  block acceptance permitted.
REQ-011 perm_req  output  1  request for a Keccak-f[1600] permutation of perm_state_out.
REQ-012 perm_state_out  output  STATE_BITS  state presented to the permutation core.
REQ-013 perm_done  input  1  permutation result valid on perm_state_in (one-cycle pulse).
REQ-014 perm_state_in  input  STATE_BITS  permuted state.
REQ-015 digest  output  DIGEST_BITS  state[255:0] once digest_valid=1.
REQ-016 digest_valid  output  1  digest ready.

Function
REQ-017 SHALL implement the states IDLE, ABSORB, PERM, PADBLK and DONE in a state register.
REQ-018 in_ready=1 exactly in IDLE, ABSORB and DONE; in_ready=0 in PERM and PADBLK.
REQ-019 Acceptance SHALL occur at a rising edge with in_valid=1 and in_ready=1; in_valid while in_ready=0 is ignored and not queued.
REQ-020 On acceptance from IDLE or DONE: state <= {0, block'}, digest_valid <= 0; from ABSORB: state[RATE_BITS-1:0] ^= block'.
REQ-021 block' = in_data when in_last=0.
REQ-022 When in_last=1 and in_nbytes<=135: bytes >= in_nbytes are zeroed, byte in_nbytes ^= 0x06, byte 135 ^= 0x80 (in_nbytes=135 gives byte135=0x86).
REQ-023 When in_last=1 and in_nbytes=136: block' = in_data unmodified and a pad-pending flag is set.
REQ-024 When in_last=1 and in_nbytes>136: treated as 136.
REQ-025 The next state after acceptance SHALL be PERM.
REQ-026 perm_req SHALL be 1 in every PERM cycle, starting the cycle after acceptance, until perm_done is sampled high.
REQ-027 perm_state_out SHALL equal the state register at all times.
REQ-028 On perm_done in PERM: state <= perm_state_in, perm_req deasserts the next cycle, and the next state is:
  - PADBLK if pad-pending;
  - DONE if the block was last;
  - ABSORB otherwise.
REQ-029 PADBLK SHALL last one cycle: state byte0 ^= 0x06, byte135 ^= 0x80, pad-pending cleared, next state PERM.
REQ-030 In DONE, digest_valid=1 and digest=state[255:0], held until the next acceptance.
REQ-031 perm_done outside PERM SHALL be ignored, with no state change.
REQ-032 perm_done in the same cycle as entry into PERM SHALL NOT be recognised (it must be sampled while in PERM).
REQ-033 Latency: single-block message with a core done after N cycles of perm_req gives digest_valid=1 at cycle N+1 after the acceptance edge.

Reset
REQ-034 rst=1 SHALL immediately force: state register 0, IDLE, pad-pending 0, perm_req=0, digest_valid=0, in_ready=1, perm_state_out=0, digest=0.
REQ-035 rst mid-PERM or mid-PADBLK SHALL abort the message; a later perm_done is ignored and the first block after reset starts a new message.

Verification
REQ-036 Empty message: in_data all 0xFF, in_last=1, in_nbytes=0 -> perm_state_out byte0=0x06, byte135=0x80, all other bits 0, perm_req=1 next cycle.
REQ-037 in_nbytes=135, in_data bytes all 0x5A -> bytes 0..134=0x5A, byte135=0x86, capacity bits 0.
REQ-038 in_nbytes=136, core returns all-ones -> two perm_req episodes; second perm_state_out = all-ones with byte0=0xF9, byte135=0x7F; digest_valid after the second perm_done.
REQ-039 Two blocks (A non-last, B last with in_nbytes=8), core returns ~state -> second perm_state_out = ~(A') ^ B'; in_ready=0 throughout PERM; in_valid held during PERM is not accepted.
REQ-040 rst pulse while perm_req=1, then perm_done pulse -> perm_req=0, IDLE, digest_valid=0, and no state change from perm_done.
REQ-041 perm_done pulsed in IDLE and in DONE -> state and digest unchanged, and digest_valid remains 1 in DONE.

Source files
------------

// File: rtl/keccak_absorb_ctrl_if.sv
// Block-input, permutation-core and digest signals of the Keccak absorb controller.
// The controller connects through the slave modport; its environment uses the master modport.
interface keccak_absorb_ctrl_if #(
    parameter int RATE_BITS   = 1088,
    parameter int STATE_BITS  = 1600,
    parameter int DIGEST_BITS = 256
);
    logic                   in_valid;
    logic [RATE_BITS-1:0]   in_data;
    logic                   in_last;
    logic [7:0]             in_nbytes;
    logic                   in_ready;
    logic                   perm_req;
    logic [STATE_BITS-1:0]  perm_state_out;
    logic                   perm_done;
    logic [STATE_BITS-1:0]  perm_state_in;
    logic [DIGEST_BITS-1:0] digest;
    logic                   digest_valid;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, perm_done, perm_state_in,
        input  in_ready, perm_req, perm_state_out, digest, digest_valid
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, perm_done, perm_state_in,
        output in_ready, perm_req, perm_state_out, digest, digest_valid
    );
endinterface

// File: rtl/keccak_absorb_ctrl.sv
// Keccak sponge absorb controller: pads and absorbs rate-sized blocks, sequences an
// external Keccak-f[1600] core, and presents the low state slice as the digest.
module keccak_absorb_ctrl #(
    parameter int RATE_BITS   = 1088,
    parameter int STATE_BITS  = 1600,
    parameter int DIGEST_BITS = 256
) (
    input logic                 local_clk,
    input logic                 rst,
    keccak_absorb_ctrl_if.slave bus
);
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int CAP_BITS   = STATE_BITS - RATE_BITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PERM   = 3'd2,
        ST_PADBLK = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Keeps the first nbytes bytes, zeroes the rest and overlays the 0x06 ... 0x80 pad.
    function automatic logic [RATE_BITS-1:0] pad_tail(
        input logic [RATE_BITS-1:0] data,
        input logic [8:0]           nbytes
    );
        logic [RATE_BITS-1:0] blk;
        logic [7:0]           byte_v;
        blk = {RATE_BITS{1'b0}};
        for (int k = 0; k < RATE_BYTES; k++) begin
            byte_v = (k < int'(nbytes)) ? data[8*k +: 8] : 8'h00;
            byte_v = byte_v ^ ((k == int'(nbytes)) ? 8'h06 : 8'h00);
            byte_v = byte_v ^ ((k == RATE_BYTES - 1) ? 8'h80 : 8'h00);
            blk[8*k +: 8] = byte_v;
        end
        return blk;
    endfunction

    // A full final block needs a trailing block that carries only the pad bytes.
    localparam logic [RATE_BITS-1:0] PAD_ONLY = pad_tail({RATE_BITS{1'b0}}, 9'd0);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [STATE_BITS-1:0] sponge_r;
    logic [STATE_BITS-1:0] sponge_nxt_s;
    logic                  pad_pend_r;
    logic                  pad_pend_nxt_s;
    logic                  last_r;
    logic                  last_nxt_s;
    logic                  in_ready_r;
    logic                  perm_req_r;
    logic                  digest_valid_r;
    logic                  accept_s;
    logic [8:0]            nbytes_eff_s;
    logic                  pad_full_s;
    logic [RATE_BITS-1:0]  block_s;

    // Clamp the byte count and form the (possibly padded) block to absorb.
    always_comb begin
        nbytes_eff_s = ({1'b0, bus.in_nbytes} > 9'(RATE_BYTES)) ? 9'(RATE_BYTES)
                                                                : {1'b0, bus.in_nbytes};
        pad_full_s   = bus.in_last && (nbytes_eff_s == 9'(RATE_BYTES));
        if (bus.in_last && !pad_full_s) begin
            block_s = pad_tail(bus.in_data, nbytes_eff_s);
        end else begin
            block_s = bus.in_data;
        end
    end

    // Next-state and sponge update logic.
    always_comb begin
        state_nxt_s    = state_r;
        sponge_nxt_s   = sponge_r;
        pad_pend_nxt_s = pad_pend_r;
        last_nxt_s     = last_r;
        accept_s       = bus.in_valid && in_ready_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    sponge_nxt_s   = {{CAP_BITS{1'b0}}, block_s};
                    pad_pend_nxt_s = pad_full_s;
                    last_nxt_s     = bus.in_last;
                    state_nxt_s    = ST_PERM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ABSORB: begin
                if (accept_s) begin
                    sponge_nxt_s[RATE_BITS-1:0] = sponge_r[RATE_BITS-1:0] ^ block_s;
                    pad_pend_nxt_s              = pad_full_s;
                    last_nxt_s                  = bus.in_last;
                    state_nxt_s                 = ST_PERM;
                end else begin
                    state_nxt_s = ST_ABSORB;
                end
            end
            ST_PERM: begin
                // perm_done is honoured only once the request is already visible.
                if (bus.perm_done) begin
                    sponge_nxt_s = bus.perm_state_in;
                    if (pad_pend_r) begin
                        state_nxt_s = ST_PADBLK;
                    end else if (last_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ABSORB;
                    end
                end else begin
                    state_nxt_s = ST_PERM;
                end
            end
            ST_PADBLK: begin
                sponge_nxt_s[RATE_BITS-1:0] = sponge_r[RATE_BITS-1:0] ^ PAD_ONLY;
                pad_pend_nxt_s              = 1'b0;
                state_nxt_s                 = ST_PERM;
            end
            default: begin
                sponge_nxt_s   = {STATE_BITS{1'b0}};
                pad_pend_nxt_s = 1'b0;
                last_nxt_s     = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // State, sponge and message-tracking registers.
    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sponge_r   <= {STATE_BITS{1'b0}};
            pad_pend_r <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sponge_r   <= sponge_nxt_s;
            pad_pend_r <= pad_pend_nxt_s;
            last_r     <= last_nxt_s;
        end
    end

    // Handshake and status outputs registered from the next state.
    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            in_ready_r     <= 1'b1;
            perm_req_r     <= 1'b0;
            digest_valid_r <= 1'b0;
        end else begin
            in_ready_r     <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ABSORB) ||
                              (state_nxt_s == ST_DONE);
            perm_req_r     <= (state_nxt_s == ST_PERM);
            digest_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.in_ready       = in_ready_r;
    assign bus.perm_req       = perm_req_r;
    assign bus.digest_valid   = digest_valid_r;
    assign bus.perm_state_out = sponge_r;
    assign bus.digest         = sponge_r[DIGEST_BITS-1:0];
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Directed bench for keccak_absorb_ctrl: a sponge-level reference model checked every
// cycle, plus hand-computed literal expectations for the padding and sequencing cases.
module tb_keccak_absorb_ctrl;
    localparam int RB  = 1088;
    localparam int SB  = 1600;
    localparam int DB  = 256;
    localparam int NBY = 136;
    localparam int M_IDLE = 0, M_ABSORB = 1, M_PERM = 2, M_PADBLK = 3, M_DONE = 4;

    logic local_clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [SB-1:0] const_pat;

    keccak_absorb_ctrl_if #(.RATE_BITS(RB), .STATE_BITS(SB), .DIGEST_BITS(DB)) bus ();

    keccak_absorb_ctrl #(.RATE_BITS(RB), .STATE_BITS(SB), .DIGEST_BITS(DB)) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial begin
        local_clk = 1'b0;
        forever #5 local_clk = ~local_clk;
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        checks++;
        if (act !== exp) begin
            int k;
            k = 0;
            while (k < SB/8 - 1 && act[8*k +: 8] === exp[8*k +: 8]) k++;
            failures++;
            $display("FAIL %s byte%0d act=%02h exp=%02h t=%0t", name, k, act[8*k +: 8], exp[8*k +: 8], $time);
        end
    endtask

    // Reference padding over a byte array.
    function automatic logic [RB-1:0] model_block(input logic [RB-1:0] d, input bit last, input int nb_raw);
        logic [7:0]    by [NBY];
        logic [RB-1:0] r;
        int            nb;
        nb = (nb_raw > NBY) ? NBY : nb_raw;
        for (int k = 0; k < NBY; k++) by[k] = d[8*k +: 8];
        if (last && nb < NBY) begin
            for (int k = nb; k < NBY; k++) by[k] = 8'h00;
            by[nb]    = by[nb] ^ 8'h06;
            by[NBY-1] = by[NBY-1] ^ 8'h80;
        end
        for (int k = 0; k < NBY; k++) r[8*k +: 8] = by[k];
        return r;
    endfunction

    logic [SB-1:0] m_state;
    int            m_mode;
    bit            m_pad;
    bit            m_last;

    // Sponge-level reference model.
    always @(posedge local_clk or posedge rst) begin
        if (rst) begin
            m_state <= '0;
            m_mode  <= M_IDLE;
            m_pad   <= 1'b0;
            m_last  <= 1'b0;
        end else if (m_mode != M_PERM && m_mode != M_PADBLK && bus.in_valid) begin
            m_state <= ((m_mode == M_ABSORB) ? m_state : {SB{1'b0}}) ^
                       {{(SB-RB){1'b0}}, model_block(bus.in_data, bus.in_last, int'(bus.in_nbytes))};
            m_pad   <= bus.in_last && (int'(bus.in_nbytes) >= NBY);
            m_last  <= bus.in_last;
            m_mode  <= M_PERM;
        end else if (m_mode == M_PERM && bus.perm_done) begin
            m_state <= bus.perm_state_in;
            m_mode  <= m_pad ? M_PADBLK : (m_last ? M_DONE : M_ABSORB);
        end else if (m_mode == M_PADBLK) begin
            m_state <= m_state ^ {{(SB-RB){1'b0}}, model_block({RB{1'b0}}, 1'b1, 0)};
            m_pad   <= 1'b0;
            m_mode  <= M_PERM;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge local_clk) begin
        chk_bit("cyc_in_ready", bus.in_ready, (m_mode != M_PERM) && (m_mode != M_PADBLK));
        chk_bit("cyc_perm_req", bus.perm_req, m_mode == M_PERM);
        chk_bit("cyc_digest_valid", bus.digest_valid, m_mode == M_DONE);
        chk_wide("cyc_state", bus.perm_state_out, m_state);
        if (m_mode == M_DONE) begin
            chk_wide("cyc_digest", {{(SB-DB){1'b0}}, bus.digest}, {{(SB-DB){1'b0}}, m_state[DB-1:0]});
        end
    end

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic send(input logic [RB-1:0] d, input bit last, input logic [7:0] nb);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_req(input int bound);
        int n;
        n = 0;
        while (bus.perm_req !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (bus.perm_req !== 1'b1) begin
            failures++;
            $display("FAIL perm_req_timeout act=0 exp=1 within %0d cycles", bound);
        end
    endtask

    // Emulated core: responds after n request cycles; mode 0 all-ones, 1 inverse, else pattern.
    task automatic core(input int n, input int mode);
        wait_req(8);
        repeat (n - 1) tick();
        bus.perm_done = 1'b1;
        case (mode)
            0:       bus.perm_state_in = {SB{1'b1}};
            1:       bus.perm_state_in = ~bus.perm_state_out;
            default: bus.perm_state_in = const_pat;
        endcase
        tick();
        bus.perm_done = 1'b0;
    endtask

    initial begin
        logic [RB-1:0] a_blk;
        logic [RB-1:0] b_blk;
        logic [RB-1:0] bp;
        logic [RB-1:0] d;
        logic [SB-1:0] e;
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_last       = 1'b0;
        bus.in_nbytes     = 8'd0;
        bus.perm_done     = 1'b0;
        bus.perm_state_in = '0;
        const_pat         = {50{32'hA5A5_0F0F}};
        #12;
        chk_bit("rst_in_ready", bus.in_ready, 1'b1);
        chk_bit("rst_perm_req", bus.perm_req, 1'b0);
        chk_bit("rst_digest_valid", bus.digest_valid, 1'b0);
        chk_wide("rst_state", bus.perm_state_out, {SB{1'b0}});
        chk_wide("rst_digest", {{(SB-DB){1'b0}}, bus.digest}, {SB{1'b0}});
        tick();
        rst = 1'b0;
        tick();

        // Empty message over an all-0xFF bus.
        send({RB{1'b1}}, 1'b1, 8'd0);
        e = '0; e[7:0] = 8'h06; e[RB-1 -: 8] = 8'h80;
        chk_wide("empty_pad", bus.perm_state_out, e);
        chk_bit("empty_req", bus.perm_req, 1'b1);
        core(2, 2);
        chk_bit("empty_dv", bus.digest_valid, 1'b1);
        chk_wide("empty_digest", {{(SB-DB){1'b0}}, bus.digest}, {{(SB-DB){1'b0}}, const_pat[DB-1:0]});

        // perm_done in DONE is ignored.
        bus.perm_done = 1'b1; bus.perm_state_in = '0;
        tick();
        bus.perm_done = 1'b0;
        chk_bit("done_pd_dv", bus.digest_valid, 1'b1);
        chk_wide("done_pd_state", bus.perm_state_out, const_pat);

        // 135 bytes, with perm_done coinciding with the acceptance edge.
        d = {NBY{8'h5A}};
        bus.perm_done = 1'b1; bus.perm_state_in = '0;
        send(d, 1'b1, 8'd135);
        bus.perm_done = 1'b0;
        e = '0; e[RB-9:0] = {135{8'h5A}}; e[RB-1 -: 8] = 8'h86;
        chk_wide("nb135_pad", bus.perm_state_out, e);
        core(1, 1);
        chk_wide("nb135_result", bus.perm_state_out, ~e);

        // Full final block (136 and an over-range 200): separate pad block.
        for (int v = 0; v < 2; v++) begin
            d = {NBY{8'h33}};
            send(d, 1'b1, (v == 0) ? 8'd136 : 8'd200);
            chk_wide("full_first", bus.perm_state_out, {{(SB-RB){1'b0}}, d});
            core(2, 0);
            chk_bit("pad_gap_req", bus.perm_req, 1'b0);
            chk_bit("pad_gap_dv", bus.digest_valid, 1'b0);
            wait_req(4);
            e = {SB{1'b1}}; e[7:0] = 8'hF9; e[RB-1 -: 8] = 8'h7F;
            chk_wide("padblk_state", bus.perm_state_out, e);
            core(1, 2);
            chk_bit("full_dv", bus.digest_valid, 1'b1);
        end

        // Two blocks; a valid presented during PERM must be dropped.
        for (int k = 0; k < NBY; k++) a_blk[8*k +: 8] = 8'(k);
        b_blk = {NBY{8'hC3}};
        send(a_blk, 1'b0, 8'd5);
        bus.in_valid = 1'b1; bus.in_data = {NBY{8'hEE}}; bus.in_last = 1'b1; bus.in_nbytes = 8'd3;
        tick();
        chk_bit("perm_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        core(2, 1);
        e = ~{{(SB-RB){1'b0}}, a_blk};
        chk_wide("absorb_state", bus.perm_state_out, e);
        chk_bit("absorb_ready", bus.in_ready, 1'b1);
        send(b_blk, 1'b1, 8'd8);
        bp = '0; bp[63:0] = b_blk[63:0]; bp[71:64] = 8'h06; bp[RB-1 -: 8] = 8'h80;
        e = e ^ {{(SB-RB){1'b0}}, bp};
        chk_wide("two_block", bus.perm_state_out, e);
        core(1, 1);
        chk_wide("two_block_digest", {{(SB-DB){1'b0}}, bus.digest}, {{(SB-DB){1'b0}}, ~e[DB-1:0]});

        // Reset mid-permutation, then a stray perm_done in IDLE.
        send(d, 1'b1, 8'd10);
        wait_req(4);
        #2; rst = 1'b1;
        #1;
        chk_bit("mid_rst_req", bus.perm_req, 1'b0);
        chk_bit("mid_rst_ready", bus.in_ready, 1'b1);
        chk_bit("mid_rst_dv", bus.digest_valid, 1'b0);
        chk_wide("mid_rst_state", bus.perm_state_out, {SB{1'b0}});
        rst = 1'b0;
        tick();
        bus.perm_done = 1'b1; bus.perm_state_in = {SB{1'b1}};
        tick();
        bus.perm_done = 1'b0;
        chk_wide("idle_pd_state", bus.perm_state_out, {SB{1'b0}});
        chk_bit("idle_pd_req", bus.perm_req, 1'b0);

        // Latency with a three-cycle core.
        send(d, 1'b1, 8'd20);
        tick();
        tick();
        chk_bit("latency_early", bus.digest_valid, 1'b0);
        bus.perm_done = 1'b1; bus.perm_state_in = const_pat;
        tick();
        bus.perm_done = 1'b0;
        chk_bit("latency_n3", bus.digest_valid, 1'b1);
        chk_wide("latency_digest", {{(SB-DB){1'b0}}, bus.digest}, {{(SB-DB){1'b0}}, const_pat[DB-1:0]});
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
